key_cmd_queue: RTL and testbench
================================

Name: key_cmd_queue

Overview:
- Sits directly downstream of the PS/2 scancode decoder, between it and the Tetris game engine.
- Converts the decoder's 9-bit key vector into encoded game commands: key-release pulses on bits [6:0], toggle levels on bits [8:7].
- Serializes simultaneous events and buffers them in a small FIFO.
- Presents commands to the game engine over a valid/ready handshake, so no keypress is lost while the engine is busy.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- HOLDOFF_CYCLES, 2500000, repeat-suppression window in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- buttons  in  9  {P, M, Esc, Space, Up, Down, Left, Right, Enter}; [6:0] are single-cycle pulses, [8:7] are toggle levels
- cmd_valid  out  1  head-of-queue command available
- cmd_ready  in  1  game engine accepts the command this cycle
- cmd_code  out  4  encoded command at queue head
- paused  out  1  registered copy of buttons[8]
- muted  out  1  registered copy of buttons[7]
- overflow  out  1  sticky; an event was lost
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): clears the FIFO, pending register, and level-history registers; all outputs go to 0.
- Command codes:
  - 1 ENTER, 2 RIGHT, 3 LEFT, 4 DOWN, 5 UP, 6 DROP (Space), 7 ESC, 8 MUTE_TGL, 9 PAUSE_TGL.
  - Code 0 never enters the queue.
- Event detection, each cycle:
  - Pulse bits [6:0] set the corresponding pending bits.
  - A change of buttons[7] vs the previous cycle sets pending[7]; a change of buttons[8] sets pending[8].
  - paused and muted update one cycle after the level change.
- Pause gating: while paused=1, pulses on bits [5:1] (moves, rotate, drop) are discarded and are not counted as overflow. ENTER, ESC and the toggles always pass.
- Serializer:
  - Each cycle, the lowest set pending bit is encoded (bit i -> code i+1) and written to the FIFO if a write is permitted; its pending bit is cleared.
  - At most one FIFO write per cycle. Remaining pending bits wait for later cycles.
- Merge rule: an event arriving for a bit already pending merges with it, and overflow is set.
- Same-cycle write and clear of the same bit: the new event wins, the bit stays pending, and overflow is not set.
- FIFO:
  - Synchronous, first-word-fall-through. cmd_code is valid whenever cmd_valid=1.
  - Pop occurs when cmd_valid & cmd_ready.
  - Full FIFO: a write is permitted only if a pop happens in the same cycle; fill_level is then unchanged.
  - Empty FIFO: cmd_valid=0, cmd_code holds its last value, and cmd_ready is ignored.
  - Read and write pointers wrap modulo DEPTH.
- Latency: pulse on buttons at edge N sets pending at edge N. The write happens at edge N+1, and cmd_valid=1 after edge N+1 (empty queue, no competing pending bits).
- Backpressure: cmd_valid and cmd_code stay stable until accepted.
- overflow stays set until reset.

Optional Feature:
- Macro: KEY_CMD_HOLDOFF_EN.
- When defined:
  - A counter suppresses a command equal to the last code written to the FIFO if it arrives within HOLDOFF_CYCLES of that write. The pending bit is cleared without a write.
  - Codes 8/9 and 1 are never suppressed.
  - The counter saturates at HOLDOFF_CYCLES and resets to 0 on every FIFO write.
- When undefined: no counter and no suppression logic; HOLDOFF_CYCLES is unused.

Decomposition:
- Shared package/include tetris_key_pkg:
  - command code constants CMD_ENTER..CMD_PAUSE_TGL, 4-bit command width;
  - button bit-index constants BTN_ENTER..BTN_P, shared with the PS/2 decoder and the game engine.
- Sub-module cmd_fifo: generic synchronous FWFT FIFO with DEPTH and WIDTH parameters, full/empty/count outputs. Reused elsewhere in the game datapath.

Test Plan:
- Reset and single key: after rst release, one-cycle pulse buttons=9'h002 -> cmd_valid=1 two edges later with cmd_code=2. Hold cmd_ready=0 for 5 cycles -> cmd_code stays 2; cmd_ready=1 -> cmd_valid=0, fill_level=0.
- Simultaneous events: buttons=9'h021 for one cycle -> queue order is cmd_code 1 then 6, fill_level reaches 2.
- Toggles and pause gating: buttons[8] 0->1 -> code 9 queued and paused=1. Pulses on bits 1..5 -> nothing queued. Pulse bit 0 -> code 1 queued. buttons[8] 1->0 -> code 9 queued, paused=0.
- Full FIFO: DEPTH+2 distinct pulses with cmd_ready=0 -> fill_level=DEPTH, extras held pending. A repeated pulse on a pending bit -> overflow=1. Draining delivers all DEPTH entries in order, then the held events.
- Full with simultaneous pop: FIFO full and a pending event, cmd_ready=1 for one cycle -> fill_level stays DEPTH and the new code appears at the tail.
- Mid-operation reset: assert rst=0 with 3 queued entries -> cmd_valid, fill_level, overflow, paused and muted go to 0 immediately (asynchronously). With KEY_CMD_HOLDOFF_EN and HOLDOFF_CYCLES=10: two RIGHT pulses 4 cycles apart -> only one code 2 queued; pulses 12 cycles apart -> two queued.

Source files
------------

// File: rtl/tetris_key_pkg.sv
// Shared key/command definitions for the PS/2 decoder, key command queue and game engine.
package tetris_key_pkg;

    localparam int unsigned CMD_W   = 4;
    localparam int unsigned NUM_BTN = 9;

    localparam int unsigned BTN_ENTER = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_DOWN  = 3;
    localparam int unsigned BTN_UP    = 4;
    localparam int unsigned BTN_SPACE = 5;
    localparam int unsigned BTN_ESC   = 6;
    localparam int unsigned BTN_M     = 7;
    localparam int unsigned BTN_P     = 8;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE      = 4'd0,
        CMD_ENTER     = 4'd1,
        CMD_RIGHT     = 4'd2,
        CMD_LEFT      = 4'd3,
        CMD_DOWN      = 4'd4,
        CMD_UP        = 4'd5,
        CMD_DROP      = 4'd6,
        CMD_ESC       = 4'd7,
        CMD_MUTE_TGL  = 4'd8,
        CMD_PAUSE_TGL = 4'd9
    } cmd_e;

    // Gameplay keys (moves, rotate, drop) that are dropped while paused.
    localparam logic [NUM_BTN-1:0] PAUSE_GATED = 9'b0_0011_1110;

    function automatic logic [CMD_W-1:0] lowest_set_idx(input logic [NUM_BTN-1:0] v);
        lowest_set_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) lowest_set_idx = CMD_W'(i);
        end
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered head, full, empty and count.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    // Head register tracks the next entry so the output holds its last value when empty.
    always_comb begin
        w_pop        = i_rd_en & (r_count != '0);
        w_push       = i_wr_en & ((r_count != CNT_W'(DEPTH)) | w_pop);
        w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
        w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_head_nxt   = r_head;
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_head_nxt = r_mem[w_rd_ptr_inc];
            end else if (w_push) begin
                w_head_nxt = i_wr_data;
            end
        end else if ((r_count == '0) && w_push) begin
            w_head_nxt = i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rd_data = r_head;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/key_cmd_queue.sv
// Turns PS/2 key events into queued game commands over valid/ready.
// Optional repeat suppression is enabled by defining KEY_CMD_HOLDOFF_EN.
module key_cmd_queue
    import tetris_key_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned HOLDOFF_CYCLES = 2500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_BTN-1:0]       buttons,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [CMD_W-1:0]         cmd_code,
    output logic                     paused,
    output logic                     muted,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);

    logic [NUM_BTN-1:0] r_pending;
    logic               r_paused;
    logic               r_muted;
    logic               r_overflow;

    logic [NUM_BTN-1:0] w_events;
    logic [NUM_BTN-1:0] w_clear;
    logic [NUM_BTN-1:0] w_sel_onehot;
    logic [CMD_W-1:0]   w_sel_idx;
    logic [CMD_W-1:0]   w_sel_code;
    logic               w_sel_valid;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_suppress;

    // New events this cycle: gated pulses plus level changes on the toggle keys.
    always_comb begin
        w_events        = buttons & ~(r_paused ? PAUSE_GATED : '0);
        w_events[BTN_M] = buttons[BTN_M] ^ r_muted;
        w_events[BTN_P] = buttons[BTN_P] ^ r_paused;
    end

    assign w_sel_valid  = |r_pending;
    assign w_sel_idx    = lowest_set_idx(r_pending);
    assign w_sel_code   = w_sel_idx + CMD_W'(1);
    assign w_sel_onehot = NUM_BTN'(1) << w_sel_idx;
    assign w_pop        = ~w_fifo_empty & cmd_ready;
    assign w_push       = w_sel_valid & ~w_suppress & (~w_fifo_full | w_pop);
    assign w_clear      = (w_push | (w_sel_valid & w_suppress)) ? w_sel_onehot : '0;

`ifdef KEY_CMD_HOLDOFF_EN
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [CMD_W-1:0]  r_last_code;

    // Counter starts saturated so the first command after reset is never suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt  <= HOLD_W'(HOLDOFF_CYCLES);
            r_last_code <= '0;
        end else if (w_push) begin
            r_hold_cnt  <= '0;
            r_last_code <= w_sel_code;
        end else if (r_hold_cnt != HOLD_W'(HOLDOFF_CYCLES)) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    assign w_suppress = w_sel_valid
                      & (w_sel_code == r_last_code)
                      & (r_hold_cnt < HOLD_W'(HOLDOFF_CYCLES))
                      & (w_sel_code != CMD_ENTER)
                      & (w_sel_code != CMD_MUTE_TGL)
                      & (w_sel_code != CMD_PAUSE_TGL);
`else
    assign w_suppress = 1'b0;
`endif

    // A new event on a bit still pending after this cycle's clear is a lost event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending  <= '0;
            r_paused   <= 1'b0;
            r_muted    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clear) | w_events;
            r_paused   <= buttons[BTN_P];
            r_muted    <= buttons[BTN_M];
            r_overflow <= r_overflow | (|(w_events & r_pending & ~w_clear));
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_sel_code),
        .i_rd_en   (cmd_ready),
        .o_rd_data (cmd_code),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (fill_level)
    );

    assign cmd_valid = ~w_fifo_empty;
    assign paused    = r_paused;
    assign muted     = r_muted;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Self-checking bench for key_cmd_queue with a queue-based reference model.
module tb_key_cmd_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned HOLD  = 10;
    localparam int unsigned FW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [8:0]    buttons   = '0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [3:0]    cmd_code;
    logic          paused;
    logic          muted;
    logic          overflow;
    logic [FW-1:0] fill_level;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int       m_q[$];
    bit [8:0] m_pend;
    bit       m_paused;
    bit       m_muted;
    bit       m_ovf;
    int       m_code;
    int       m_last;
    int       m_cnt;

    always #5 clk = ~clk;

    key_cmd_queue #(
        .DEPTH          (DEPTH),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .paused     (paused),
        .muted      (muted),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    task automatic model_reset();
        m_q.delete();
        m_pend   = '0;
        m_paused = 1'b0;
        m_muted  = 1'b0;
        m_ovf    = 1'b0;
        m_code   = 0;
        m_last   = 0;
        m_cnt    = HOLD;
    endtask

    // One clock edge of the behavioural model, using inputs as seen at that edge.
    task automatic model_edge();
        bit       pop;
        bit       wrote;
        bit       supp;
        int       sel;
        int       code;
        bit [8:0] ev;
        bit [8:0] clr;
        pop   = (m_q.size() > 0) && cmd_ready;
        sel   = -1;
        wrote = 1'b0;
        clr   = '0;
        code  = 0;
        for (int i = 0; i < 9; i++) begin
            if (m_pend[i] && sel < 0) sel = i;
        end
        if (sel >= 0) begin
            code = sel + 1;
            supp = 1'b0;
`ifdef KEY_CMD_HOLDOFF_EN
            supp = (code == m_last) && (m_cnt < HOLD) && (code != 1) && (code != 8) && (code != 9);
`endif
            if (supp) begin
                clr[sel] = 1'b1;
            end else if (m_q.size() < DEPTH || pop) begin
                clr[sel] = 1'b1;
                wrote    = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (wrote) m_q.push_back(code);
        if (wrote) begin
            m_cnt  = 0;
            m_last = code;
        end else if (m_cnt < HOLD) begin
            m_cnt++;
        end
        ev = '0;
        for (int i = 0; i < 7; i++) begin
            if (buttons[i] && !(m_paused && i >= 1 && i <= 5)) ev[i] = 1'b1;
        end
        ev[7] = (buttons[7] != m_muted);
        ev[8] = (buttons[8] != m_paused);
        if ((ev & m_pend & ~clr) != '0) m_ovf = 1'b1;
        m_pend   = (m_pend & ~clr) | ev;
        m_muted  = buttons[7];
        m_paused = buttons[8];
        if (m_q.size() > 0) m_code = m_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; buttons = '0; cmd_ready = 1'b0;
        repeat (3) tick();
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", cmd_valid); end
        n_tests++; if (fill_level !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0d expected 0", overflow); end
        n_tests++; if (paused !== 1'b0 || muted !== 1'b0) begin n_fail++; $display("FAIL reset_levels: got paused=%0d muted=%0d expected 0 0", paused, muted); end
        n_tests++; if (cmd_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", cmd_code); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_key();
        buttons = 9'h002; tick(); buttons = '0;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid=%0d expected 0", cmd_valid); end
        tick();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_code !== 4'd2) begin n_fail++; $display("FAIL single_first: got valid=%0d code=%0d expected 1 2", cmd_valid, cmd_code); end
        repeat (5) begin
            tick();
            n_tests++; if (cmd_valid !== 1'b1 || cmd_code !== 4'd2) begin n_fail++; $display("FAIL single_hold: got valid=%0d code=%0d expected 1 2", cmd_valid, cmd_code); end
        end
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        n_tests++; if (cmd_valid !== 1'b0 || fill_level !== '0) begin n_fail++; $display("FAIL single_pop: got valid=%0d fill=%0d expected 0 0", cmd_valid, fill_level); end
    endtask

    task automatic test_simultaneous();
        buttons = 9'h021; tick(); buttons = '0;
        tick();
        n_tests++; if (fill_level !== FW'(1) || cmd_code !== 4'd1) begin n_fail++; $display("FAIL simul_first: got fill=%0d code=%0d expected 1 1", fill_level, cmd_code); end
        tick();
        n_tests++; if (fill_level !== FW'(2) || cmd_code !== 4'd1) begin n_fail++; $display("FAIL simul_both: got fill=%0d code=%0d expected 2 1", fill_level, cmd_code); end
        cmd_ready = 1'b1; tick();
        n_tests++; if (fill_level !== FW'(1) || cmd_code !== 4'd6) begin n_fail++; $display("FAIL simul_second: got fill=%0d code=%0d expected 1 6", fill_level, cmd_code); end
        tick(); cmd_ready = 1'b0;
        n_tests++; if (cmd_valid !== 1'b0 || cmd_code !== 4'd6) begin n_fail++; $display("FAIL simul_empty_hold: got valid=%0d code=%0d expected 0 6", cmd_valid, cmd_code); end
    endtask

    task automatic test_toggles();
        buttons = 9'h100; tick();
        n_tests++; if (paused !== 1'b1) begin n_fail++; $display("FAIL toggle_paused: got %0d expected 1", paused); end
        tick();
        n_tests++; if (fill_level !== FW'(1) || cmd_code !== 4'd9) begin n_fail++; $display("FAIL toggle_code9: got fill=%0d code=%0d expected 1 9", fill_level, cmd_code); end
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            buttons = 9'h100 | (9'h001 << b); tick();
        end
        buttons = 9'h100;
        repeat (3) tick();
        n_tests++; if (fill_level !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL pause_gate: got fill=%0d ovf=%0d expected 0 0", fill_level, overflow); end
        buttons = 9'h101; tick(); buttons = 9'h100; tick();
        n_tests++; if (fill_level !== FW'(1) || cmd_code !== 4'd1) begin n_fail++; $display("FAIL pause_enter: got fill=%0d code=%0d expected 1 1", fill_level, cmd_code); end
        buttons = '0; tick();
        n_tests++; if (paused !== 1'b0) begin n_fail++; $display("FAIL toggle_unpause: got %0d expected 0", paused); end
        tick();
        n_tests++; if (fill_level !== FW'(2)) begin n_fail++; $display("FAIL toggle_fill2: got %0d expected 2", fill_level); end
        cmd_ready = 1'b1; tick();
        n_tests++; if (cmd_code !== 4'd9) begin n_fail++; $display("FAIL toggle_second9: got %0d expected 9", cmd_code); end
        tick(); cmd_ready = 1'b0;
    endtask

    task automatic test_full();
        int got[$];
        int exp_codes [10];
        exp_codes = '{1, 2, 3, 4, 5, 6, 7, 1, 2, 3};
        cmd_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            buttons = 9'h001 << ((k < 7) ? k : k - 7); tick();
        end
        buttons = '0; tick();
        n_tests++; if (fill_level !== FW'(DEPTH) || overflow !== 1'b0) begin n_fail++; $display("FAIL full_fill: got fill=%0d ovf=%0d expected %0d 0", fill_level, overflow, DEPTH); end
        buttons = 9'h002; tick(); buttons = '0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_merge_ovf: got %0d expected 1", overflow); end
        cmd_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            if (cmd_valid) got.push_back(int'(cmd_code));
            tick();
        end
        cmd_ready = 1'b0;
        n_tests++; if (got.size() != 10) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_tests++; if (got[i] != exp_codes[i]) begin n_fail++; $display("FAIL full_drain_order[%0d]: got %0d expected %0d", i, got[i], exp_codes[i]); end
        end
        tick();
        n_tests++; if (fill_level !== '0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", fill_level); end
    endtask

    task automatic test_full_pop();
        int got[$];
        int bits [9];
        bits = '{0, 1, 2, 3, 4, 5, 6, 0, 3};
        for (int k = 0; k < 9; k++) begin
            buttons = 9'h001 << bits[k]; tick();
        end
        buttons = '0; tick();
        n_tests++; if (fill_level !== FW'(DEPTH)) begin n_fail++; $display("FAIL fullpop_pre: got %0d expected %0d", fill_level, DEPTH); end
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        n_tests++; if (fill_level !== FW'(DEPTH) || cmd_code !== 4'd2) begin n_fail++; $display("FAIL fullpop_same: got fill=%0d code=%0d expected %0d 2", fill_level, cmd_code, DEPTH); end
        cmd_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < DEPTH; c++) begin
            if (cmd_valid) got.push_back(int'(cmd_code));
            tick();
        end
        cmd_ready = 1'b0;
        n_tests++; if (got.size() != DEPTH || got[got.size() - 1] != 4) begin n_fail++; $display("FAIL fullpop_tail: got n=%0d last=%0d expected %0d 4", got.size(), (got.size() > 0) ? got[got.size() - 1] : -1, DEPTH); end
    endtask

    task automatic test_midreset();
        buttons = 9'h180; tick();
        buttons = 9'h181; tick();
        buttons = 9'h180;
        repeat (4) tick();
        n_tests++; if (fill_level !== FW'(3) || paused !== 1'b1 || muted !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got fill=%0d p=%0d m=%0d ovf=%0d expected 3 1 1 1", fill_level, paused, muted, overflow); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (cmd_valid !== 1'b0 || fill_level !== '0 || overflow !== 1'b0 || paused !== 1'b0 || muted !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got v=%0d fill=%0d ovf=%0d p=%0d m=%0d expected all 0", cmd_valid, fill_level, overflow, paused, muted); end
        buttons = '0;
        model_reset();
        tick();
        rst = 1'b1;
        tick();
    endtask

`ifdef KEY_CMD_HOLDOFF_EN
    task automatic test_holdoff();
        buttons = 9'h002; tick(); buttons = '0;
        repeat (3) tick();
        buttons = 9'h002; tick(); buttons = '0;
        repeat (3) tick();
        n_tests++; if (fill_level !== FW'(1)) begin n_fail++; $display("FAIL holdoff_close: got %0d expected 1", fill_level); end
        repeat (15) tick();
        buttons = 9'h002; tick(); buttons = '0;
        repeat (11) tick();
        buttons = 9'h002; tick(); buttons = '0;
        repeat (3) tick();
        n_tests++; if (fill_level !== FW'(3)) begin n_fail++; $display("FAIL holdoff_far: got %0d expected 3", fill_level); end
        cmd_ready = 1'b1;
        repeat (5) tick();
        cmd_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            logic [8:0] b;
            b = buttons & 9'h180;
            if ($urandom_range(15) == 0) b[7] = ~b[7];
            if ($urandom_range(15) == 0) b[8] = ~b[8];
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(5) == 0) b[i] = 1'b1;
            end
            buttons   = b;
            cmd_ready = ($urandom_range(1) == 1);
            tick();
            n_tests++;
            if (cmd_valid !== (m_q.size() > 0) || fill_level !== FW'(m_q.size()) ||
                cmd_code !== 4'(m_code) || paused !== m_paused || muted !== m_muted || overflow !== m_ovf) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL random[%0d]: got v=%0d fill=%0d code=%0d p=%0d m=%0d ovf=%0d expected %0d %0d %0d %0d %0d %0d",
                    c, cmd_valid, fill_level, cmd_code, paused, muted, overflow,
                    (m_q.size() > 0), m_q.size(), m_code, m_paused, m_muted, m_ovf);
            end
        end
        buttons   = '0;
        cmd_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_key();
        test_simultaneous();
        test_toggles();
        test_full();
        test_full_pop();
        test_midreset();
`ifdef KEY_CMD_HOLDOFF_EN
        test_holdoff();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
